// File: rtl/kmer_assembler_if.sv
// Handshake and data bundle between a k-mer producer/consumer (master) and kmer_assembler (slave).
interface kmer_assembler_if;
  logic         load;
  logic [511:0] read_in;
  logic         kmer_valid;
  logic [97:0]  kmer_in;
  logic         kmer_last;
  logic         kmer_ready;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] read_out;
  logic [7:0]   kmer_cnt;
  logic         err;

  modport master (
    output load, read_in, kmer_valid, kmer_in, kmer_last, out_ready,
    input  kmer_ready, out_valid, read_out, kmer_cnt, err
  );

  modport slave (
    input  load, read_in, kmer_valid, kmer_in, kmer_last, out_ready,
    output kmer_ready, out_valid, read_out, kmer_cnt, err
  );
endinterface

// File: rtl/kmer_assembler.sv
// Overlays 45-base k-mers onto a 256-base read and presents the assembled read downstream.
// Optional feature macro KMER_ASSEMBLER_ORDER_CHECK_EN rejects k-mers whose pos does not strictly increase.
module kmer_assembler (
  input  logic            clk,
  input  logic            reset,
  kmer_assembler_if.slave bus
);
  localparam int NUM_BASES = 256;
  localparam int KMER_LEN  = 45;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [511:0] r_read;
  logic [511:0] w_read_next;
  logic [7:0]   r_cnt;
  logic [7:0]   w_pos;
  logic [89:0]  w_bases;
  logic [1:0]   w_kb [0:KMER_LEN-1];
  logic         w_accept;
  logic         w_reject;
  logic         w_write;
  logic         w_load;
  logic         w_err;

  assign w_pos    = bus.kmer_in[97:90];
  assign w_bases  = bus.kmer_in[89:0];
  assign w_accept = bus.kmer_valid && (r_state == COLLECT);
  assign w_load   = bus.load && (r_state == IDLE);
  assign w_write  = w_accept && !w_reject;

`ifdef KMER_ASSEMBLER_ORDER_CHECK_EN
  logic [7:0] r_last_pos;
  logic       r_have_last;
  logic       r_err;

  // Every accepted k-mer, rejected or not, becomes the new reference position.
  assign w_reject = r_have_last && (w_pos <= r_last_pos);
  assign w_err    = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_pos  <= 8'd0;
      r_have_last <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_load) begin
      r_last_pos  <= 8'd0;
      r_have_last <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_last_pos  <= w_pos;
      r_have_last <= 1'b1;
      if (w_reject) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_reject = 1'b0;
  assign w_err    = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < KMER_LEN; gi++) begin : g_kbase
      assign w_kb[gi] = w_bases[89-2*gi -: 2];
    end
  endgenerate

  // Each read base picks k-mer base (b - pos) when that offset lands inside the k-mer;
  // offsets past base 255 simply have no matching read base, so nothing wraps.
  generate
    for (gi = 0; gi < NUM_BASES; gi++) begin : g_rbase
      localparam logic [8:0] LP_IDX = 9'(gi);
      logic [8:0] w_off;
      logic       w_hit;
      assign w_off = LP_IDX - {1'b0, w_pos};
      assign w_hit = (w_off < 9'(KMER_LEN));
      assign w_read_next[511-2*gi -: 2] = w_hit ? w_kb[w_off[5:0]] : r_read[511-2*gi -: 2];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.load) w_state_next = COLLECT;
      COLLECT: if (w_accept && bus.kmer_last) w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_read <= '0;
      r_cnt  <= 8'd0;
    end else if (w_load) begin
      r_read <= bus.read_in;
      r_cnt  <= 8'd0;
    end else if (w_write) begin
      r_read <= w_read_next;
      if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.kmer_ready = (r_state == COLLECT);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.read_out   = r_read;
  assign bus.kmer_cnt   = r_cnt;
  assign bus.err        = w_err;
endmodule

// File: tb/tb_kmer_assembler.sv
// Self-checking bench for kmer_assembler: directed scenarios plus randomized reads against a base-array model.
module tb_kmer_assembler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kmer_assembler_if bus();
  kmer_assembler dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: one integer per base, plus counters.
  int m_base [256];
  int m_cnt;
  bit m_err;
  bit m_have;
  int m_last;
  int k_b [45];

  task automatic chk_read(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] model_read();
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 256; j++) r[511-2*j -: 2] = 2'(m_base[j]);
    return r;
  endfunction

  function automatic logic [511:0] rand_read();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  task automatic check_all(input string tag, input logic exp_valid, input logic exp_ready);
    chk_bit({tag, ".out_valid"}, bus.out_valid, exp_valid);
    chk_bit({tag, ".kmer_ready"}, bus.kmer_ready, exp_ready);
    chk_read({tag, ".read_out"}, bus.read_out, model_read());
    chk_cnt({tag, ".kmer_cnt"}, bus.kmer_cnt, 8'(m_cnt));
    chk_bit({tag, ".err"}, bus.err, m_err);
  endtask

  task automatic model_clear();
    for (int j = 0; j < 256; j++) m_base[j] = 0;
    m_cnt = 0; m_err = 1'b0; m_have = 1'b0; m_last = 0;
  endtask

  task automatic model_apply(input int pos);
    bit ok;
    ok = 1'b1;
`ifdef KMER_ASSEMBLER_ORDER_CHECK_EN
    if (m_have && pos <= m_last) begin
      ok = 1'b0;
      m_err = 1'b1;
    end
    m_have = 1'b1;
    m_last = pos;
`endif
    if (ok) begin
      for (int i = 0; i < 45; i++) if (pos + i <= 255) m_base[pos+i] = k_b[i];
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 45; i++) k_b[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 45; i++) k_b[i] = int'($urandom_range(0, 3));
  endtask

  function automatic logic [97:0] make_kmer(input int pos);
    logic [89:0] b;
    for (int i = 0; i < 45; i++) b[89-2*i -: 2] = 2'(k_b[i]);
    return {8'(pos), b};
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check_all(tag, 1'b0, 1'b0);
    $display("reset %s", tag);
  endtask

  task automatic load_read(input logic [511:0] data);
    bus.read_in = data;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    model_clear();
    for (int j = 0; j < 256; j++) m_base[j] = int'(data[511-2*j -: 2]);
    check_all("load", 1'b0, 1'b1);
    $display("load read");
  endtask

  task automatic send_kmer(input string tag, input int pos, input bit last);
    int waited;
    bus.kmer_in = make_kmer(pos);
    bus.kmer_last = last;
    bus.kmer_valid = 1'b1;
    waited = 0;
    while (!bus.kmer_ready && waited < 16) begin
      tick();
      waited++;
    end
    if (waited >= 16) chk_bit({tag, ".ready_timeout"}, bus.kmer_ready, 1'b1);
    tick();
    bus.kmer_valid = 1'b0;
    bus.kmer_last = 1'b0;
    model_apply(pos);
    check_all(tag, last, !last);
    $display("kmer %s pos=%0d last=%0d cnt=%0d err=%0d", tag, pos, last, bus.kmer_cnt, bus.err);
  endtask

  task automatic finish_read(input string tag, input int stall);
    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      bus.read_in = rand_read();
      bus.load = 1'b1;
      tick();
      check_all({tag, ".stall"}, 1'b1, 1'b0);
    end
    bus.load = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_all({tag, ".release"}, 1'b0, 1'b0);
    $display("output %s stall=%0d cnt=%0d", tag, stall, m_cnt);
  endtask

  initial begin
    bus.load = 1'b0; bus.read_in = '0; bus.kmer_valid = 1'b0; bus.kmer_in = '0;
    bus.kmer_last = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    do_reset("initial");

    // Three abutting all-3 k-mers over a zero read.
    load_read('0);
    fill_const(3);
    send_kmer("abut0", 0, 1'b0);
    send_kmer("abut45", 45, 1'b0);
    send_kmer("abut90", 90, 1'b1);
    chk_read("abut.literal", bus.read_out, {{270{1'b1}}, {242{1'b0}}});
    chk_cnt("abut.cnt3", bus.kmer_cnt, 8'd3);
    finish_read("abut", 2);

    // Tail k-mer must be clipped at base 255.
    load_read(rand_read());
    fill_const(1);
    send_kmer("tail250", 250, 1'b1);
    finish_read("tail", 1);

    // Overlap: later k-mer wins; five-cycle backpressure in DONE.
    load_read(rand_read());
    fill_const(2);
    send_kmer("ovl10", 10, 1'b0);
    fill_const(1);
    send_kmer("ovl20", 20, 1'b1);
    finish_read("ovl", 5);

    // Descending positions (rejected only when order checking is built in).
    load_read(rand_read());
    fill_rand();
    send_kmer("ord50", 50, 1'b0);
    fill_rand();
    send_kmer("ord40", 40, 1'b1);
    finish_read("ord", 1);

    // Reset mid-COLLECT overrides a concurrent load and k-mer handshake.
    load_read(rand_read());
    fill_rand();
    send_kmer("mid0", int'($urandom_range(0, 200)), 1'b0);
    fill_rand();
    send_kmer("mid1", 210, 1'b0);
    bus.kmer_in = make_kmer(220);
    bus.kmer_valid = 1'b1;
    bus.read_in = rand_read();
    bus.load = 1'b1;
    reset = 1'b1;
    tick();
    model_clear();
    check_all("midreset", 1'b0, 1'b0);
    reset = 1'b0;
    bus.load = 1'b0;
    tick();
    check_all("postreset", 1'b0, 1'b0);

    // k-mer words presented in IDLE have no effect.
    tick();
    check_all("idle_kmer", 1'b0, 1'b0);
    bus.kmer_valid = 1'b0;
    $display("idle kmer ignored");

    // Randomized reads with ignored load pulses during COLLECT.
    for (int r = 0; r < 8; r++) begin
      int n;
      load_read(rand_read());
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.read_in = rand_read();
          bus.load = 1'b1;
          tick();
          bus.load = 1'b0;
          check_all("load_ignored", 1'b0, 1'b1);
        end
        fill_rand();
        send_kmer("rnd", int'($urandom_range(0, 255)), k == n - 1);
      end
      finish_read("rnd", int'($urandom_range(0, 3)));
    end

    // Counter saturation at 255.
    load_read(rand_read());
    for (int k = 0; k < 260; k++) begin
      fill_rand();
      send_kmer("sat", int'($urandom_range(0, 255)), k == 259);
    end
    finish_read("sat", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/kmer_assembler.md
KMER_ASSEMBLER -- requirements
Module: kmer_assembler

Interface
REQ-001 SHALL have port clk  in  1  single rising-edge clock.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port load  in  1  one-cycle pulse; captures read_in as the base read.
REQ-004 SHALL have port read_in  in  512  base read, 256 bases x 2 bits; base j at bits [511-2j:510-2j].
REQ-005 SHALL have port kmer_valid  in  1  k-mer word present.
REQ-006 SHALL have port kmer_in  in  98  {pos[97:90], bases[89:0]}; k-mer base i at bits [89-2i:88-2i], i=0..44.
REQ-007 SHALL have port kmer_last  in  1  qualifies kmer_in as the final k-mer of the read.
REQ-008 SHALL have port kmer_ready  out  1  assembler accepts kmer_in this cycle.
REQ-009 SHALL have port out_valid  out  1  read_out holds the assembled read.
REQ-010 SHALL have port out_ready  in  1  downstream accepts read_out.
REQ-011 SHALL have port read_out  out  512  assembled read, same bit layout as read_in.
REQ-012 SHALL have port kmer_cnt  out  8  number of k-mers written for the current read, saturating at 255.
REQ-013 SHALL have port err  out  1  sticky order-violation flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-015 IDLE: load=1 -> read register <= read_in, kmer_cnt <= 0, err <= 0, last_pos tracker cleared, state <= COLLECT; otherwise hold.
REQ-016 kmer_ready SHALL be 1 exactly when state==COLLECT; a k-mer is accepted on a cycle with kmer_valid & kmer_ready.
REQ-017 Accepted k-mer SHALL overwrite read bases pos+i with k-mer base i for i=0..44; it SHALL be visible in read_out on the next cycle.
REQ-018 Bases with pos+i > 255 SHALL be discarded; no wrap to base 0.
REQ-019 Each accepted k-mer SHALL increment kmer_cnt by 1, holding at 255 once reached.
REQ-020 Overlapping k-mers: the later-accepted k-mer wins on every overlapped base.
REQ-021 Accepted k-mer with kmer_last=1 SHALL move the FSM to DONE on the next cycle, with its bases already written.
REQ-022 DONE: out_valid=1, read_out and kmer_cnt stable; out_valid & out_ready -> IDLE next cycle.
REQ-023 out_valid SHALL be 0 in IDLE and COLLECT; read_out SHALL always reflect the internal read register.
REQ-024 load in COLLECT or DONE SHALL be ignored.
REQ-025 kmer_valid while kmer_ready=0 SHALL have no effect; the producer holds the word until accepted.

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE, read_out=0, kmer_cnt=0, err=0, out_valid=0, kmer_ready=0, overriding load and any handshake that cycle.
REQ-027 reset during COLLECT or DONE SHALL abandon the partial read with no output transfer.

Configuration
REQ-028 Macro KMER_ASSEMBLER_ORDER_CHECK_EN SHALL control position-order checking.
REQ-029 With the macro defined: an accepted k-mer whose pos is less than or equal to the pos of the previous accepted k-mer of the same read SHALL set err and SHALL NOT be written or counted; kmer_last on such a k-mer still moves the FSM to DONE.
REQ-030 Without the macro: any pos order SHALL be accepted and written, and err SHALL be constant 0.

Verification
REQ-031 read_in all-zero, load; k-mers pos=0, pos=45, pos=90 (last), all bases 2'b11 -> out_valid 1 cycle after last; bases 0..134 = 3, 135..255 = 0; kmer_cnt=3.
REQ-032 k-mer pos=250, bases all 2'b01, last -> bases 250..255 = 1; bases 0..249 equal read_in; no wrap.
REQ-033 Overlap: pos=10 all 2'b10, then pos=20 all 2'b01 (last) -> bases 10..19 = 2, bases 20..64 = 1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid and read_out stable; kmer_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 With macro: pos=50 then pos=40 -> err=1, second k-mer not written, kmer_cnt=1. Without macro: both written, err=0.
REQ-036 reset asserted mid-COLLECT after 2 k-mers -> next cycle IDLE, kmer_cnt=0, read_out=0, out_valid=0.
